// File: rtl/mult_gen_pkg.sv
// Shared types and default sizing for the sequential multiple generator.
package mult_gen_pkg;

  localparam int MG_WIDTH  = 4;
  localparam int MG_FACTOR = 4;
  localparam int MG_OUT_W  = 6;

  // 2'b11 is unused and is steered back to IDLE by the next-state logic.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mult_gen.sv
// Sequential multiple generator: product = k*FACTOR built by adding FACTOR
// once per clock while a down-counter loaded with k runs out.
module mult_gen
  import mult_gen_pkg::*;
#(
  parameter int WIDTH  = MG_WIDTH,
  parameter int FACTOR = MG_FACTOR,
  parameter int OUT_W  = MG_OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] product,
  output logic             overflow
);

  // Handshake: start is accepted only in IDLE or DONE, where k is latched;
  // busy is high for the whole RUN phase, done pulses for one cycle when
  // product becomes valid. start while busy is dropped, never queued.

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic [WIDTH-1:0] cnt;
  logic [OUT_W-1:0] acc;
  logic [OUT_W:0]   sum;

  always_comb begin
    state_nxt = IDLE;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN:  state_nxt = (cnt == '0) ? DONE : RUN;
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Extra top bit captures the carry out of the OUT_W-bit accumulator.
  assign sum = {1'b0, acc} + (OUT_W + 1)'(FACTOR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      product  <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt      <= k;
        acc      <= '0;
        overflow <= 1'b0;
      end else if (state == RUN) begin
        // Counter is tested before decrementing, so it never underflows.
        if (cnt == '0) begin
          product <= acc;
        end else begin
          acc <= sum[OUT_W-1:0];
          cnt <= cnt - WIDTH'(1);
          if (sum[OUT_W]) overflow <= 1'b1;
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mult_gen.sv
// Bench for mult_gen: a default-sized instance plus a narrow OUT_W=5 instance
// for wrap/overflow, checked against k*FACTOR arithmetic.
module tb_mult_gen;

  localparam int FACTOR = 4;
  localparam int OW0    = 6;
  localparam int OW1    = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       drv_start = 1'b0;
  logic [3:0] drv_k = '0;
  logic       sel = 1'b0;

  logic           start0, start1;
  logic           busy0, done0, ovf0;
  logic           busy1, done1, ovf1;
  logic [OW0-1:0] product0;
  logic [OW1-1:0] product1;

  int obs_busy, obs_done, obs_product, obs_ovf;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    int k;
    int product;
    int ovf;
    int lat;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  assign start0 = sel ? 1'b0 : drv_start;
  assign start1 = sel ? drv_start : 1'b0;

  assign obs_busy    = sel ? int'(busy1) : int'(busy0);
  assign obs_done    = sel ? int'(done1) : int'(done0);
  assign obs_product = sel ? int'(product1) : int'(product0);
  assign obs_ovf     = sel ? int'(ovf1) : int'(ovf0);

  mult_gen #(.WIDTH(4), .FACTOR(FACTOR), .OUT_W(OW0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .k(drv_k),
    .busy(busy0), .done(done0), .product(product0), .overflow(ovf0)
  );

  mult_gen #(.WIDTH(4), .FACTOR(FACTOR), .OUT_W(OW1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .k(drv_k),
    .busy(busy1), .done(done1), .product(product1), .overflow(ovf1)
  );

  function automatic int model_product(input int kv, input int ow);
    return (kv * FACTOR) % (1 << ow);
  endfunction

  function automatic int model_ovf(input int kv, input int ow);
    return ((kv * FACTOR) >= (1 << ow)) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pop_exp();
    if (exp_q.size() == 0) return -1;
    return int'(exp_q.pop_front());
  endfunction

  // One operation from IDLE: start sampled at edge T, done expected after
  // edge T+k+1 with busy high for the k+1 edges before it.
  task automatic run_op(input bit s, input int kv, input int exp_ov, input int exp_lat);
    int  lat;
    int  busy_cnt;
    int  both;
    bit  seen;
    int  held;
    sel       = s;
    drv_k     = 4'(kv);
    drv_start = 1'b1;
    tick();
    drv_start = 1'b0;
    drv_k     = 4'($urandom_range(0, 15));
    lat = 0; busy_cnt = 0; both = 0; seen = 1'b0;
    if (obs_busy == 1) busy_cnt++;
    for (int i = 1; i <= 40; i++) begin
      tick();
      lat = i;
      if (obs_busy == 1 && obs_done == 1) both++;
      if (obs_done == 1) begin
        seen = 1'b1;
        break;
      end
      if (obs_busy == 1) busy_cnt++;
    end
    if (!seen) begin
      check("op_timeout", 0, 1);
    end else begin
      check("op_latency", lat, exp_lat);
      check("op_busy_cycles", busy_cnt, exp_lat);
      check("op_busy_done_overlap", both, 0);
      check("op_product", obs_product, pop_exp());
      check("op_overflow", obs_ovf, exp_ov);
      held = obs_product;
      tick();
      check("op_done_pulse", obs_done, 0);
      check("op_product_held", obs_product, held);
    end
  endtask

  initial begin
    int  lat;
    int  gaps;
    int  dones;
    int  nb;
    bit  seen;
    int  kv;
    int  ow;

    vecs[0] = '{k: 3,  product: 12, ovf: 0, lat: 4};
    vecs[1] = '{k: 15, product: 60, ovf: 0, lat: 16};
    vecs[2] = '{k: 0,  product: 0,  ovf: 0, lat: 1};
    vecs[3] = '{k: 1,  product: 4,  ovf: 0, lat: 2};
    vecs[4] = '{k: 7,  product: 28, ovf: 0, lat: 8};
    vecs[5] = '{k: 10, product: 40, ovf: 0, lat: 11};

    // Reset held with start asserted: nothing may leave IDLE.
    rst_n = 1'b0; drv_start = 1'b1; drv_k = 4'd9;
    tick(); tick();
    check("rst_busy", int'(busy0), 0);
    check("rst_done", int'(done0), 0);
    check("rst_product", int'(product0), 0);
    check("rst_overflow", int'(ovf0), 0);
    drv_start = 1'b0;
    rst_n = 1'b1;
    tick();
    check("rst_stay_idle", int'(busy0 | done0), 0);

    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(8'(vecs[i].product));
      run_op(1'b0, vecs[i].k, vecs[i].ovf, vecs[i].lat);
    end

    // Narrow instance: 15*4 = 60 wraps to 28 and flags overflow; next op clears it.
    exp_q.push_back(8'(28));
    run_op(1'b1, 15, 1, 16);
    exp_q.push_back(8'(4));
    run_op(1'b1, 1, 0, 2);

    // start pulsed during RUN with a different k must be ignored.
    sel = 1'b0;
    exp_q.push_back(8'(20));
    drv_k = 4'd5; drv_start = 1'b1;
    tick();
    drv_start = 1'b0;
    tick();
    drv_k = 4'd2; drv_start = 1'b1;
    tick();
    drv_start = 1'b0;
    lat = 2; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if (done0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("ignore_timeout", 0, 1);
    else begin
      check("ignore_latency", lat, 6);
      check("ignore_product", int'(product0), pop_exp());
    end
    nb = 0; dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy0) nb++;
      if (done0) dones++;
    end
    check("ignore_no_second_busy", nb, 0);
    check("ignore_no_second_done", dones, 0);

    // Back-to-back: start held high, next k presented during the DONE cycle.
    exp_q.push_back(8'(8));
    exp_q.push_back(8'(4));
    drv_k = 4'd2; drv_start = 1'b1;
    tick();
    lat = 0; gaps = 0; dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if (!(busy0 | done0)) gaps++;
      if (done0) begin
        dones++;
        check("b2b_product", int'(product0), pop_exp());
        check("b2b_latency", lat, (dones == 1) ? 3 : 3);
        lat = 0;
        if (dones == 1) drv_k = 4'd1;
        else begin
          drv_start = 1'b0;
          break;
        end
      end
    end
    drv_start = 1'b0;
    check("b2b_done_count", dones, 2);
    check("b2b_idle_gap", gaps, 0);
    tick();
    check("b2b_back_to_idle", int'(busy0 | done0), 0);

    // Reset in the third RUN cycle aborts with no done and cleared outputs.
    drv_k = 4'd5; drv_start = 1'b1;
    tick();
    drv_start = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    check("abort_busy", int'(busy0), 0);
    check("abort_done", int'(done0), 0);
    check("abort_product", int'(product0), 0);
    check("abort_overflow", int'(ovf0), 0);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done0 | busy0) dones++;
    end
    check("abort_no_done", dones, 0);

    // Randomized operations on both instances against plain arithmetic.
    for (int i = 0; i < 16; i++) begin
      kv = int'($urandom_range(0, 15));
      ow = ($urandom_range(0, 1) == 1) ? OW1 : OW0;
      exp_q.push_back(8'(model_product(kv, ow)));
      run_op((ow == OW1), kv, model_ovf(kv, ow), kv + 1);
    end

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
